pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the team's single-bit half/full adder cells.
- Adds or subtracts two WIDTH-bit operands, splitting the carry chain into STAGES registered slices so it closes timing at FPGA clock rates.
- Valid/ready handshake on both sides, so it drops into streaming datapaths between the switch/LED top-level and arithmetic units.
- Produces sum, carry-out and signed overflow.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/adder_slice.sv | 31 +++
 rtl/pipelined_addsub.sv | 162 ++++++++++++++++
 tb/tb_pipelined_addsub.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared helpers for the pipelined adder/subtractor: slice sizing,
// configuration check and the per-stage control record.
package addsub_pkg;

  function automatic int slice_w(input int width, input int stages);
    return (stages < 1) ? 0 : width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

  // Control part of a stage payload; the partial sum and the remaining
  // operand bits have stage-dependent widths and live beside it.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple of full-adder cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module adder_slice
  import addsub_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_top
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  genvar gi;
  for (gi = 0; gi < SLICE; gi++) begin : g_fa
    logic p;
    assign p       = a[gi] ^ b[gi];
    assign s[gi]   = p ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (p & c[gi]);
  end

  assign cout  = c[SLICE];
  assign c_top = c[SLICE-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered
// slices; valid/ready on both sides, whole pipeline stalls as one.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a nonzero multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_q, ovf_d;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub | cin;

  genvar gi;

  // Skew registers after stage gi carry the operand bits not yet consumed.
  for (gi = 0; gi < STAGES - 1; gi++) begin : g_skew
    localparam int RW = WIDTH - (gi + 1) * SLICE;

    logic [RW-1:0] opa_src, opb_src;
    logic [RW-1:0] opa_q, opa_d;
    logic [RW-1:0] opb_q, opb_d;

    if (gi == 0) begin : g_src_in
      assign opa_src = a[WIDTH-1:SLICE];
      assign opb_src = b_eff[WIDTH-1:SLICE];
    end else begin : g_src_prev
      assign opa_src = g_skew[gi-1].opa_q[RW+SLICE-1:SLICE];
      assign opb_src = g_skew[gi-1].opb_q[RW+SLICE-1:SLICE];
    end

    always_comb begin
      opa_d = opa_q;
      opb_d = opb_q;
      if (adv) begin
        opa_d = opa_src;
        opb_d = opb_src;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        opa_q <= '0;
        opb_q <= '0;
      end else begin
        opa_q <= opa_d;
        opb_q <= opb_d;
      end
    end
  end

  // Stage gi adds one slice and appends it to the de-skewed lower result.
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SLICE;
    localparam int PW = LO + SLICE;

    logic [SLICE-1:0] a_in, b_in, s_out;
    logic             c_in, c_out, c_top;
    logic             vld_in;
    logic [PW-1:0]    psum_new;
    logic [PW-1:0]    psum_q, psum_d;
    stage_ctl_t       ctl_q, ctl_d;

    if (gi == 0) begin : g_head
      assign a_in     = a[SLICE-1:0];
      assign b_in     = b_eff[SLICE-1:0];
      assign c_in     = cin_eff;
      assign vld_in   = in_valid;
      assign psum_new = s_out;
    end else begin : g_body
      assign a_in     = g_skew[gi-1].opa_q[SLICE-1:0];
      assign b_in     = g_skew[gi-1].opb_q[SLICE-1:0];
      assign c_in     = g_stage[gi-1].ctl_q.carry;
      assign vld_in   = g_stage[gi-1].ctl_q.valid;
      assign psum_new = {s_out, g_stage[gi-1].psum_q};
    end

    if (gi != STAGES - 1) begin : g_mid
      logic unused_c_top;
      assign unused_c_top = c_top;
    end

    adder_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a     (a_in),
      .b     (b_in),
      .cin   (c_in),
      .s     (s_out),
      .cout  (c_out),
      .c_top (c_top)
    );

    always_comb begin
      ctl_d  = ctl_q;
      psum_d = psum_q;
      if (adv) begin
        ctl_d.valid = vld_in;
        ctl_d.carry = c_out;
        psum_d      = psum_new;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q  <= '0;
        psum_q <= '0;
      end else begin
        ctl_q  <= ctl_d;
        psum_q <= psum_d;
      end
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = g_stage[STAGES-1].c_top ^ g_stage[STAGES-1].c_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].ctl_q.valid;
  assign cout      = g_stage[STAGES-1].ctl_q.carry;
  assign sum       = g_stage[STAGES-1].psum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed + random bench for pipelined_addsub against an arithmetic
// reference model held in a result queue.
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int S = 4;
  localparam longint MOD  = longint'(1) << W;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  pipelined_addsub #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic xcin, input logic xsub);
    exp_t   e;
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(xa);
    ub = longint'(xb);
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    if (xsub) begin
      ures   = ua - ub;
      sres   = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      ures   = ua + ub + longint'(xcin);
      sres   = sa + sb + longint'(xcin);
      e.cout = (ures >= MOD);
    end
    e.sum = W'(ures);
    e.ovf = (sres > SMAX) || (sres < SMIN);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Call with inputs driven and settled; books the handshakes of this cycle.
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      chk("pending_result", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("txn out sum=%h cout=%0d ovf=%0d (model sum=%h cout=%0d ovf=%0d)",
                 sum, cout, ovf, e.sum, e.cout, e.ovf);
        chk("res_sum", 32'(sum), 32'(e.sum));
        chk("res_cout", 32'(cout), 32'(e.cout));
        chk("res_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xcin, input logic xsub, input logic [W-1:0] esum,
                          input logic ecout, input logic eovf);
    int n;
    a = xa; b = xb; cin = xcin; sub = xsub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (n < 40) begin
      #1;
      if (out_valid) break;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(S));
    chk({tag, "_sum"}, 32'(sum), 32'(esum));
    chk({tag, "_cout"}, 32'(cout), 32'(ecout));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    tick();
  endtask

  initial begin
    int   sent, got, cyc, seen, acc, guard;
    bit   prev_stall;
    logic [W-1:0] held_sum;
    logic held_cout, held_ovf;
    bit   iv[12];
    bit   ov[12];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed arithmetic corners
    send_one("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("sovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_one("slicecy",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send_one("cin",      16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    send_one("borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("subovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_one("subeq",    16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure stream: a=i, b=2i, stall three cycles mid-stream
    sent = 0; got = 0; cyc = 0; prev_stall = 0;
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (sent < 8);
      a = W'(sent); b = W'(2 * sent); cin = 1'b0; sub = 1'b0;
      #1;
      if (prev_stall) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_sum_held", 32'(sum), 32'(held_sum));
        chk("stall_cout_held", 32'(cout), 32'(held_cout));
        chk("stall_ovf_held", 32'(ovf), 32'(held_ovf));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        chk("stream_order", 32'(sum), 32'(3 * got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      held_sum = sum; held_cout = cout; held_ovf = ovf;
      tick();
      cyc++;
    end
    chk("stream_count", 32'(got), 32'd8);
    in_valid = 1'b0; out_ready = 1'b1;

    // Bubbles: in_valid 1,0,1 must reappear on out_valid S cycles later
    for (int c = 0; c < 12; c++) begin
      in_valid = (c == 0 || c == 2);
      a = W'($urandom); b = W'($urandom); cin = 1'b0; sub = 1'b0;
      #1;
      iv[c] = in_valid;
      ov[c] = out_valid;
      tick();
    end
    for (int c = 0; c < 8; c++) chk($sformatf("bubble_%0d", c), 32'(ov[c+S]), 32'(iv[c]));

    // Reset with beats in flight
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = (i == 0) ? 16'h7FFF : W'($urandom);
      b = (i == 0) ? 16'h0001 : W'($urandom);
      cin = 1'b0; sub = 1'b0;
      #1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("prerst_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) seen++;
      tick();
    end
    chk("postrst_no_stale", 32'(seen), 32'd0);
    send_one("postrst", 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0);

    // Random traffic with random backpressure
    acc = 0; guard = 0;
    while (acc < 200 && guard < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      #1;
      chk("rand_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (in_valid && in_ready) acc++;
      tick();
      guard++;
    end
    chk("rand_accepted", 32'(acc), 32'd200);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      #1;
      tick();
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
